// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with valid/ready on both sides.
// Two-entry skid buffer keeps id_ready a flop; flush squashes all entries.
module id_ex_pipe #(
  parameter int DATA_W   = 32,
  parameter int REGA_W   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [DATA_W-1:0]   id_reg1,
  input  logic [DATA_W-1:0]   id_reg2,
  input  logic [REGA_W-1:0]   id_wd,
  input  logic                id_wreg,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [DATA_W-1:0]   ex_reg1,
  output logic [DATA_W-1:0]   ex_reg2,
  output logic [REGA_W-1:0]   ex_wd,
  output logic                ex_wreg
);

  localparam int PW = ALUSEL_W + ALUOP_W + 2 * DATA_W + REGA_W + 1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_nxt;
  logic          id_ready_q;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic [PW-1:0] id_pl;
  logic [PW-1:0] ex_pl;
  logic          accept;
  logic          emit;
  logic          main_ld;
  logic          main_from_skid;
  logic          skid_ld;

  assign id_pl  = {id_alusel, id_aluop, id_reg1, id_reg2, id_wd, id_wreg};
  assign accept = id_valid & id_ready_q;
  assign emit   = ex_valid & ex_ready;

  always_comb begin
    state_nxt      = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_nxt = S_FULL;
            main_ld   = 1'b1;
          end
        end
        S_FULL: begin
          if (accept && emit) begin
            main_ld = 1'b1;
          end else if (accept) begin
            state_nxt = S_SKID;
            skid_ld   = 1'b1;
          end else if (emit) begin
            state_nxt = S_EMPTY;
          end
        end
        S_SKID: begin
          if (emit) begin
            state_nxt      = S_FULL;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_EMPTY;
      id_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_nxt;
      id_ready_q <= (state_nxt != S_SKID);
      if (main_ld)
        main_q <= main_from_skid ? skid_q : id_pl;
      if (skid_ld)
        skid_q <= id_pl;
    end
  end

  // An empty stage presents a bubble instead of stale MAIN contents.
  assign ex_valid = (state_q != S_EMPTY);
  assign id_ready = id_ready_q;
  assign ex_pl    = ex_valid ? main_q : '0;

  assign {ex_alusel, ex_aluop, ex_reg1, ex_reg2, ex_wd, ex_wreg} = ex_pl;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed vector table, async reset, and a
// random run checked against a queue-based model.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [2:0]  id_alusel;
  logic [7:0]  id_aluop;
  logic [31:0] id_reg1;
  logic [31:0] id_reg2;
  logic [4:0]  id_wd;
  logic        id_wreg;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_alusel;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [4:0]  ex_wd;
  logic        ex_wreg;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_alusel(id_alusel),
    .id_aluop (id_aluop),
    .id_reg1  (id_reg1),
    .id_reg2  (id_reg2),
    .id_wd    (id_wd),
    .id_wreg  (id_wreg),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_alusel(ex_alusel),
    .ex_aluop (ex_aluop),
    .ex_reg1  (ex_reg1),
    .ex_reg2  (ex_reg2),
    .ex_wd    (ex_wd),
    .ex_wreg  (ex_wreg)
  );

  typedef struct packed {
    logic [2:0]  alusel;
    logic [7:0]  aluop;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
  } pl_t;

  typedef struct {
    logic        fl;
    logic        iv;
    logic        er;
    logic [31:0] r1;
    logic [4:0]  wd;
    logic        e_v;
    logic        e_rdy;
    logic [31:0] e_r1;
    logic [4:0]  e_wd;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic drive(input logic fl, input logic iv, input logic er,
                       input logic [31:0] r1, input logic [4:0] wd);
    flush     = fl;
    id_valid  = iv;
    ex_ready  = er;
    id_reg1   = r1;
    id_reg2   = ~r1;
    id_wd     = wd;
    id_alusel = 3'd4;
    id_aluop  = 8'h5a;
    id_wreg   = 1'b1;
  endtask

  function automatic pl_t dut_pl();
    pl_t p;
    p = {ex_alusel, ex_aluop, ex_reg1, ex_reg2, ex_wd, ex_wreg};
    return p;
  endfunction

  vec_t vt[$];
  pl_t  q[$];
  pl_t  exp_pl;
  pl_t  nw;

  initial begin
    vt = '{
      // stream 1..4
      '{0,1,1,32'd1, 5'd1, 1,1,32'd1, 5'd1},
      '{0,1,1,32'd2, 5'd2, 1,1,32'd2, 5'd2},
      '{0,1,1,32'd3, 5'd3, 1,1,32'd3, 5'd3},
      '{0,1,1,32'd4, 5'd4, 1,1,32'd4, 5'd4},
      // three bubbles then resume
      '{0,0,1,32'd0, 5'd0, 0,1,32'd0, 5'd0},
      '{0,0,1,32'd0, 5'd0, 0,1,32'd0, 5'd0},
      '{0,0,1,32'd0, 5'd0, 0,1,32'd0, 5'd0},
      '{0,1,1,32'd5, 5'd7, 1,1,32'd5, 5'd7},
      '{0,0,1,32'd0, 5'd0, 0,1,32'd0, 5'd0},
      // backpressure A(wd=5), B(wd=6)
      '{0,1,0,32'd10,5'd5, 1,1,32'd10,5'd5},
      '{0,1,0,32'd11,5'd6, 1,0,32'd10,5'd5},
      '{0,1,0,32'd12,5'd9, 1,0,32'd10,5'd5},
      '{0,0,0,32'd0, 5'd0, 1,0,32'd10,5'd5},
      '{0,0,1,32'd0, 5'd0, 1,1,32'd11,5'd6},
      '{0,0,1,32'd0, 5'd0, 0,1,32'd0, 5'd0},
      // flush in SKID with C offered
      '{0,1,0,32'd20,5'd3, 1,1,32'd20,5'd3},
      '{0,1,0,32'd21,5'd4, 1,0,32'd20,5'd3},
      '{1,1,0,32'd22,5'd8, 0,1,32'd0, 5'd0},
      // flush in FULL discards same-cycle accept
      '{0,1,0,32'd30,5'd10,1,1,32'd30,5'd10},
      '{1,1,1,32'd31,5'd11,0,1,32'd0, 5'd0},
      '{0,0,1,32'd0, 5'd0, 0,1,32'd0, 5'd0},
      '{0,1,1,32'd40,5'd12,1,1,32'd40,5'd12}
    };

    rst = 1'b0;
    drive(0, 0, 0, 32'd0, 5'd0);
    @(negedge clk);
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_id_ready", id_ready, 1'b1);
    check("rst_bubble", dut_pl(), '0);
    rst = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].fl, vt[i].iv, vt[i].er, vt[i].r1, vt[i].wd);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), ex_valid, vt[i].e_v);
      check($sformatf("vec%0d_ready", i), id_ready, vt[i].e_rdy);
      check($sformatf("vec%0d_reg1", i), ex_reg1, vt[i].e_r1);
      check($sformatf("vec%0d_wd", i), ex_wd, vt[i].e_wd);
      check($sformatf("vec%0d_wreg", i), ex_wreg, vt[i].e_v);
      check($sformatf("vec%0d_aluop", i), ex_aluop,
            vt[i].e_v ? 8'h5a : 8'h00);
    end

    // Fill to SKID, then assert reset between edges.
    drive(0, 1, 0, 32'd50, 5'd14);
    @(negedge clk);
    check("pre_rst_skid", id_ready, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", ex_valid, 1'b0);
    check("async_rst_wreg", ex_wreg, 1'b0);
    check("async_rst_aluop", ex_aluop, 8'h00);
    check("async_rst_ready", id_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1, 1, 32'd60, 5'd13);
    @(negedge clk);
    check("post_rst_valid", ex_valid, 1'b1);
    check("post_rst_reg1", ex_reg1, 32'd60);
    drive(0, 0, 1, 32'd0, 5'd0);
    @(negedge clk);
    check("drain_valid", ex_valid, 1'b0);

    // Random traffic; model is a plain FIFO of capacity 2.
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      flush    = ($urandom_range(0, 63) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      nw.alusel = 3'($urandom);
      nw.aluop  = 8'($urandom);
      nw.reg1   = $urandom;
      nw.reg2   = $urandom;
      nw.wd     = 5'($urandom);
      nw.wreg   = 1'($urandom);
      {id_alusel, id_aluop, id_reg1, id_reg2, id_wd, id_wreg} = nw;
      if (flush) begin
        q.delete();
      end else begin
        automatic bit acc = id_valid && (q.size() < 2);
        automatic bit em  = (q.size() > 0) && ex_ready;
        if (em) void'(q.pop_front());
        if (acc) q.push_back(nw);
      end
      @(negedge clk);
      exp_pl = (q.size() > 0) ? q[0] : '0;
      check("rnd_valid", ex_valid, q.size() > 0);
      check("rnd_ready", id_ready, q.size() < 2);
      check("rnd_payload", dut_pl(), exp_pl);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
